// File: rtl/if_pkg.sv
// Shared types and constants for the outstanding-request fetch stage.
// Buffer entries carry the PC, instruction and any fetch exception.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1C000000;

  localparam int EX_CODE_W = 15;

  localparam logic [5:0] ECODE_ADE     = 6'h08;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic                 ex;
    logic [EX_CODE_W-1:0] code;
    logic [31:0]          vaddr;
  } if_buf_t;

  localparam int IF_BUF_W = $bits(if_buf_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear, occupancy count and simultaneous push/pop.
// Head data is read combinationally; storage is not reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = nxt(wr_q);
    if (do_pop)  rd_d = nxt(rd_q);
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/if_stage_ob.sv
// Instruction fetch with multiple outstanding requests and an inst buffer.
// Redirects cancel in-flight responses; misaligned PCs yield an ADEF entry.
module if_stage_ob
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          OUTSTANDING = 2,
  parameter int          BUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ex_ra,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_ex,
  output logic [14:0] if_ex_code,
  output logic [31:0] if_ex_vaddr
);

  localparam int QW = $clog2(OUTSTANDING + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] OUT_LIM = OUTSTANDING;
  localparam logic [31:0] BUF_LIM = BUF_DEPTH;

  logic [31:0]   pf_pc_q, pf_pc_d;
  logic [QW-1:0] cancel_cnt_q, cancel_cnt_d;
  logic          halt_q, halt_d;

  logic [QW-1:0] live_cnt;
  logic [31:0]   pcq_head;
  logic          pcq_full, pcq_empty;
  logic [BW-1:0] buf_cnt;
  logic          buf_full, buf_empty;
  if_buf_t       buf_head, buf_din;

  logic          redirect;
  logic [31:0]   target;
  logic [31:0]   occ_q, occ_all;
  logic          accept, drop, take, adef;
  logic          buf_push, buf_pop;

  assign redirect = wb_ex | ertn_flush | br_taken;

  always_comb begin
    target = br_target;
    if (wb_ex)           target = ex_entry;
    else if (ertn_flush) target = ex_ra;
  end

  // Reserve buffer room for every request that may still answer.
  assign occ_q   = 32'(live_cnt) + 32'(cancel_cnt_q);
  assign occ_all = occ_q + 32'(buf_cnt);

  assign inst_req = !reset && !redirect && !halt_q &&
                    pf_pc_q[1:0] == 2'b00 && !pcq_full &&
                    occ_q < OUT_LIM && occ_all < BUF_LIM;
  assign inst_addr = pf_pc_q;

  assign accept = inst_req & inst_addr_ok;
  assign drop   = inst_data_ok && cancel_cnt_q != '0;
  assign take   = inst_data_ok && cancel_cnt_q == '0 && !pcq_empty;
  assign adef   = !redirect && !halt_q &&
                  pf_pc_q[1:0] != 2'b00 && !buf_full;

  always_comb begin
    buf_din = '0;
    if (take) begin
      buf_din.pc   = pcq_head;
      buf_din.inst = inst_rdata;
    end else begin
      buf_din.pc    = pf_pc_q;
      buf_din.ex    = 1'b1;
      buf_din.code  = {ESUBCODE_ADEF, ECODE_ADE};
      buf_din.vaddr = pf_pc_q;
    end
  end

  assign buf_push       = take | adef;
  assign if_to_id_valid = !buf_empty && !redirect;
  assign buf_pop        = if_to_id_valid & id_allowin;

  assign if_pc       = buf_head.pc;
  assign if_inst     = buf_head.inst;
  assign if_ex       = buf_head.ex;
  assign if_ex_code  = buf_head.code;
  assign if_ex_vaddr = buf_head.vaddr;

  always_comb begin
    pf_pc_d      = pf_pc_q;
    cancel_cnt_d = cancel_cnt_q - QW'(drop);
    halt_d       = halt_q;
    if (adef)   halt_d  = 1'b1;
    if (accept) pf_pc_d = pf_pc_q + 32'd4;
    // A live response landing on the redirect cycle is already gone.
    if (redirect) begin
      pf_pc_d      = target;
      halt_d       = 1'b0;
      cancel_cnt_d = cancel_cnt_q - QW'(drop) + live_cnt - QW'(take);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_pc_q      <= RESET_PC;
      cancel_cnt_q <= '0;
      halt_q       <= 1'b0;
    end else begin
      pf_pc_q      <= pf_pc_d;
      cancel_cnt_q <= cancel_cnt_d;
      halt_q       <= halt_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (OUTSTANDING)
  ) u_pc_q (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (accept),
    .din   (pf_pc_q),
    .pop   (take),
    .dout  (pcq_head),
    .count (live_cnt),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  sync_fifo #(
    .WIDTH (IF_BUF_W),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buf (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (buf_push),
    .din   (buf_din),
    .pop   (buf_pop),
    .dout  (buf_head),
    .count (buf_cnt),
    .full  (buf_full),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_if_stage_ob.sv
// Randomized bench for if_stage_ob with an in-order slave memory and a
// stream-level model of the PC sequence ID must observe.
module tb_if_stage_ob;
  import if_pkg::*;

  localparam int          OUT = 2;
  localparam int          BD  = 4;
  localparam logic [31:0] RPC = 32'h1C000000;
  localparam logic [31:0] K   = 32'hA5A5A5A5;

  logic        clk, reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        wb_ex, ertn_flush, br_taken, id_allowin;
  logic [31:0] ex_entry, ex_ra, br_target;
  logic        if_to_id_valid, if_ex;
  logic [31:0] if_pc, if_inst, if_ex_vaddr;
  logic [14:0] if_ex_code;

  if_stage_ob #(
    .RESET_PC    (RPC),
    .OUTSTANDING (OUT),
    .BUF_DEPTH   (BD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .wb_ex          (wb_ex),
    .ex_entry       (ex_entry),
    .ertn_flush     (ertn_flush),
    .ex_ra          (ex_ra),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .id_allowin     (id_allowin),
    .if_to_id_valid (if_to_id_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_ex          (if_ex),
    .if_ex_code     (if_ex_code),
    .if_ex_vaddr    (if_ex_vaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } req_t;

  req_t        sq[$];
  int          checks, failures;
  logic [31:0] m_fetch, m_id;
  int          m_buf;
  bit          m_halt;
  bit          slv_hold;
  int          addr_rate, data_rate;
  bit          s_req, s_valid, s_pop, s_ex;
  logic [31:0] s_addr, s_pc;
  logic [14:0] s_code;
  logic [31:0] s_vaddr;

  // One clock: entered just after negedge with stimulus applied.
  task automatic step();
    logic [31:0] tgt, a;
    bit redir, exp_req, exp_valid, acc, dok, adef, pop;
    req_t h;
    redir = wb_ex | ertn_flush | br_taken;
    tgt = wb_ex ? ex_entry : (ertn_flush ? ex_ra : br_target);
    inst_addr_ok = ($urandom_range(99) < addr_rate);
    dok = !slv_hold && sq.size() > 0 && $urandom_range(99) < data_rate;
    inst_data_ok = dok;
    inst_rdata = dok ? (sq[0].addr ^ K) : $urandom;
    #1;
    exp_req = !reset && !redir && !m_halt && m_fetch[1:0] == 2'b00 &&
              sq.size() < OUT && sq.size() + m_buf < BD;
    exp_valid = m_buf > 0 && !redir;
    checks++;
    if (inst_req !== exp_req) begin
      failures++;
      $display("FAIL inst_req: got %b exp %b t=%0t", inst_req, exp_req, $time);
    end
    checks++;
    if (if_to_id_valid !== exp_valid) begin
      failures++;
      $display("FAIL valid: got %b exp %b t=%0t", if_to_id_valid, exp_valid, $time);
    end
    if (exp_req) begin
      checks++;
      if (inst_addr !== m_fetch) begin
        failures++;
        $display("FAIL inst_addr: got %h exp %h", inst_addr, m_fetch);
      end
    end
    pop = exp_valid && id_allowin;
    if (pop) begin
      checks++;
      if (m_id[1:0] != 2'b00) begin
        if (if_ex !== 1'b1 || if_ex_code !== 15'h0008 ||
            if_ex_vaddr !== m_id || if_pc !== m_id) begin
          failures++;
          $display("FAIL adef_entry: got ex=%b code=%h va=%h pc=%h exp va/pc=%h",
                   if_ex, if_ex_code, if_ex_vaddr, if_pc, m_id);
        end
      end else if (if_ex !== 1'b0 || if_pc !== m_id || if_inst !== (m_id ^ K)) begin
        failures++;
        $display("FAIL id_entry: got pc=%h inst=%h ex=%b exp pc=%h inst=%h",
                 if_pc, if_inst, if_ex, m_id, m_id ^ K);
      end
    end
    s_req = inst_req; s_addr = inst_addr; s_valid = if_to_id_valid;
    s_pc = if_pc; s_ex = if_ex; s_code = if_ex_code; s_vaddr = if_ex_vaddr;
    s_pop = pop;
    a = inst_addr;
    acc = exp_req && inst_addr_ok;
    adef = !reset && !redir && !m_halt && m_fetch[1:0] != 2'b00 && m_buf < BD;
    @(posedge clk);
    if (reset) begin
      sq.delete(); m_buf = 0; m_halt = 0; m_fetch = RPC; m_id = RPC;
    end else begin
      if (dok) begin
        h = sq.pop_front();
        if (!h.stale && !redir) m_buf++;
      end
      if (pop) begin m_buf--; m_id += 4; end
      if (adef) begin m_buf++; m_halt = 1; end
      if (acc) sq.push_back('{addr: a, stale: 1'b0});
      if (acc) m_fetch += 4;
      if (redir) begin
        foreach (sq[i]) sq[i].stale = 1'b1;
        m_buf = 0; m_halt = 0; m_fetch = tgt; m_id = tgt;
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_redirect();
    wb_ex = 0; ertn_flush = 0; br_taken = 0;
  endtask

  task automatic do_reset();
    reset = 1; clr_redirect(); step(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) step();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b0 || s_ex !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got req=%b valid=%b ex=%b exp 0 0 0", s_req, s_valid, s_ex);
    end
    reset = 0;
  endtask

  task automatic test_stream();
    addr_rate = 100; data_rate = 100; slv_hold = 0; id_allowin = 1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c < 3) begin
        checks++;
        if (!s_req || s_addr !== RPC + 32'(4 * c)) begin
          failures++;
          $display("FAIL stream_req%0d: got %b/%h exp 1/%h", c, s_req, s_addr, RPC + 32'(4 * c));
        end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (s_valid !== (c == 2)) begin
          failures++;
          $display("FAIL stream_first_valid c%0d: got %b", c, s_valid);
        end
      end
      if (c >= 2) begin
        checks++;
        if (!s_valid || s_pc !== RPC + 32'(4 * (c - 2))) begin
          failures++;
          $display("FAIL stream_rate c%0d: got %b/%h exp 1/%h", c, s_valid, s_pc, RPC + 32'(4 * (c - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    id_allowin = 0;
    repeat (10) step();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_full: got req=%b valid=%b exp 0 1", s_req, s_valid);
    end
    id_allowin = 1;
    repeat (12) step();
  endtask

  task automatic test_redirect_cancel();
    bit found = 0;
    do_reset();
    slv_hold = 1; addr_rate = 100; id_allowin = 1;
    repeat (2) step();
    br_taken = 1; br_target = 32'h1C000100;
    step();
    clr_redirect(); slv_hold = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_pop) begin
        found = 1;
        checks++;
        if (s_pc !== 32'h1C000100) begin
          failures++;
          $display("FAIL cancel_first: got %h exp 1c000100", s_pc);
        end
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL cancel_timeout: got none exp pop");
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp_t [2];
    bit found;
    exp_t[0] = 32'h1C008000;
    exp_t[1] = 32'h1C000400;
    for (int k = 0; k < 2; k++) begin
      wb_ex = (k == 0); ertn_flush = 1; br_taken = 1;
      ex_entry = 32'h1C008000; ex_ra = 32'h1C000400; br_target = 32'h1C000300;
      step();
      clr_redirect();
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
        step();
        if (s_req) begin
          found = 1;
          checks++;
          if (s_addr !== exp_t[k]) begin
            failures++;
            $display("FAIL priority%0d: got %h exp %h", k, s_addr, exp_t[k]);
          end
        end
      end
      if (!found) begin
        checks++; failures++;
        $display("FAIL priority_timeout%0d: got no req", k);
      end
      repeat (4) step();
    end
  endtask

  task automatic test_adef();
    bit found = 0;
    id_allowin = 0;
    br_taken = 1; br_target = 32'h1C000102;
    step();
    clr_redirect();
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = s_valid;
    end
    checks++;
    if (!found || s_ex !== 1'b1 || s_code !== 15'h0008 || s_vaddr !== 32'h1C000102) begin
      failures++;
      $display("FAIL adef_head: got v=%b ex=%b code=%h va=%h exp 1 1 0008 1c000102",
               found, s_ex, s_code, s_vaddr);
    end
    id_allowin = 1;
    step();
    repeat (5) step();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL adef_halt: got req=%b valid=%b exp 0 0", s_req, s_valid);
    end
    wb_ex = 1; ex_entry = 32'h1C000200;
    step();
    clr_redirect();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_pop) begin
        found = 1;
        checks++;
        if (s_pc !== 32'h1C000200) begin
          failures++;
          $display("FAIL adef_resume: got %h exp 1c000200", s_pc);
        end
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL adef_resume_timeout: got none");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    id_allowin = 0; slv_hold = 1;
    repeat (2) step();
    slv_hold = 0;
    repeat (2) step();
    slv_hold = 1;
    repeat (2) step();
    reset = 1;
    step();
    reset = 0; slv_hold = 0;
    step();
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== RPC) begin
      failures++;
      $display("FAIL reset_mid: got valid=%b req=%b addr=%h exp 0 1 %h",
               s_valid, s_req, s_addr, RPC);
    end
    id_allowin = 1;
  endtask

  task automatic test_random();
    int r;
    addr_rate = 70; data_rate = 60; slv_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      id_allowin = ($urandom_range(99) < 70);
      r = $urandom_range(99);
      if (r < 3) begin
        wb_ex = $urandom_range(1); ertn_flush = $urandom_range(1); br_taken = 1;
        ex_entry  = 32'h1C000000 + {$urandom_range(1023), 2'b00};
        ex_ra     = 32'h1C010000 + {$urandom_range(1023), 2'b00};
        br_target = 32'h1C020000 + {$urandom_range(1023), 2'b00};
        if ($urandom_range(7) == 0) br_target[1:0] = 2'($urandom_range(1, 3));
      end
      reset = ($urandom_range(999) == 0);
      step();
      clr_redirect(); reset = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    reset = 1; clr_redirect(); id_allowin = 0;
    ex_entry = 0; ex_ra = 0; br_target = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    slv_hold = 0; addr_rate = 100; data_rate = 100;
    m_fetch = RPC; m_id = RPC; m_buf = 0; m_halt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_cancel();
    test_priority();
    test_adef();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
